// File: rtl/div_pipe_if.sv
// div_pipe_if: operand/result bundle for the pipelined divider.
// The master drives operands and the stall; the slave (div_pipe) returns
// quotient, remainder, the valid tag and the divide-by-zero flag.
interface div_pipe_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  hold;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] numer;
    logic [DATA_WIDTH-1:0] denom;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] quotient;
    logic [DATA_WIDTH-1:0] remain;
    logic                  div_zero;

    modport master (
        output hold,
        output in_valid,
        output numer,
        output denom,
        input  out_valid,
        input  quotient,
        input  remain,
        input  div_zero
    );

    modport slave (
        input  hold,
        input  in_valid,
        input  numer,
        input  denom,
        output out_valid,
        output quotient,
        output remain,
        output div_zero
    );
endinterface

// File: rtl/div_pipe.sv
// div_pipe: fully pipelined restoring integer divider.
// Input register -> DATA_WIDTH/BITS_PER_STAGE restoring stages -> output
// register, so a result appears STAGES+2 non-stalled cycles after capture.
// Signed mode divides magnitudes and restores signs in the output register.
// Optional build macro DIV_ZERO_DETECT_EN: carries a per-operation zero-divisor
// flag down the pipe, drives div_zero and forces the divide-by-zero results.
// Without it div_zero is tied low and no zero-detect logic exists.
module div_pipe #(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_STAGE = 1,
    parameter int SIGNED         = 0
) (
    input  logic      clock,
    input  logic      rst,
    div_pipe_if.slave bus
);
    localparam int W      = DATA_WIDTH;
    localparam int STAGES = DATA_WIDTH / BITS_PER_STAGE;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    generate
        if (DATA_WIDTH < 4) begin : g_bad_width
            $error("div_pipe: DATA_WIDTH must be at least 4");
        end
        if ((DATA_WIDTH % BITS_PER_STAGE) != 0) begin : g_bad_split
            $error("div_pipe: BITS_PER_STAGE must divide DATA_WIDTH");
        end
    endgenerate

    // Two's-complement negate when neg is set, pass through otherwise.
    function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
        logic [W-1:0] res;
        if (neg) begin
            res = ~v + ONE;
        end else begin
            res = v;
        end
        return res;
    endfunction

    // One restoring step: shift the next dividend bit into the partial
    // remainder, subtract the divisor if it fits, shift the quotient bit in.
    // qn holds the not-yet-consumed dividend bits at the top and the
    // quotient bits produced so far at the bottom.
    function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem,
                                                input logic [W-1:0] qn,
                                                input logic [W-1:0] den);
        logic [W:0]   trial;
        logic [W:0]   diff;
        logic [W-1:0] rem_n;
        logic [W-1:0] qn_n;
        trial = {rem, qn[W-1]};
        diff  = trial - {1'b0, den};
        qn_n  = {qn[W-2:0], 1'b0};
        if (trial >= {1'b0, den}) begin
            rem_n   = diff[W-1:0];
            qn_n[0] = 1'b1;
        end else begin
            rem_n   = trial[W-1:0];
            qn_n[0] = 1'b0;
        end
        return {rem_n, qn_n};
    endfunction

    // Index 0 is the input register, 1..STAGES are the division stages.
    logic         r_valid [0:STAGES];
    logic [W-1:0] r_rem   [0:STAGES];
    logic [W-1:0] r_qn    [0:STAGES];
    logic [W-1:0] r_den   [0:STAGES];
    logic         r_sn    [0:STAGES];
    logic         r_sd    [0:STAGES];
`ifdef DIV_ZERO_DETECT_EN
    logic         r_zero  [0:STAGES];
    logic         r_div_zero;
`endif

    logic         r_out_valid;
    logic [W-1:0] r_quotient;
    logic [W-1:0] r_remain;

    logic         w_neg_n;
    logic         w_neg_d;
    logic [W-1:0] w_abs_n;
    logic [W-1:0] w_abs_d;
    logic [W-1:0] w_rem   [1:STAGES];
    logic [W-1:0] w_qn    [1:STAGES];
    logic [W-1:0] w_q_fix;
    logic [W-1:0] w_r_fix;
    logic [W-1:0] w_q_res;
    logic [W-1:0] w_r_res;

    // Operand signs and magnitudes for the input register.
    always_comb begin
        w_neg_n = 1'b0;
        w_neg_d = 1'b0;
        if (SIGNED != 0) begin
            w_neg_n = bus.numer[W-1];
            w_neg_d = bus.denom[W-1];
        end else begin
            w_neg_n = 1'b0;
            w_neg_d = 1'b0;
        end
        w_abs_n = cond_neg(bus.numer, w_neg_n);
        w_abs_d = cond_neg(bus.denom, w_neg_d);
    end

    // Each stage resolves BITS_PER_STAGE quotient bits from the previous stage's state.
    always_comb begin
        logic [W-1:0] v_rem;
        logic [W-1:0] v_qn;
        v_rem = {W{1'b0}};
        v_qn  = {W{1'b0}};
        for (int k = 1; k <= STAGES; k++) begin
            v_rem = r_rem[k-1];
            v_qn  = r_qn[k-1];
            for (int b = 0; b < BITS_PER_STAGE; b++) begin
                {v_rem, v_qn} = div_step(v_rem, v_qn, r_den[k-1]);
            end
            w_rem[k] = v_rem;
            w_qn[k]  = v_qn;
        end
    end

    // Sign restoration and divide-by-zero override feeding the output register.
    always_comb begin
        w_q_fix = r_qn[STAGES];
        w_r_fix = r_rem[STAGES];
        if (SIGNED != 0) begin
            w_q_fix = cond_neg(r_qn[STAGES], r_sn[STAGES] ^ r_sd[STAGES]);
            w_r_fix = cond_neg(r_rem[STAGES], r_sn[STAGES]);
        end else begin
            w_q_fix = r_qn[STAGES];
            w_r_fix = r_rem[STAGES];
        end
`ifdef DIV_ZERO_DETECT_EN
        // With a zero divisor every step subtracts nothing, so the partial
        // remainder ends as |numer|; restoring its sign returns numer itself.
        if (r_zero[STAGES]) begin
            w_q_res = {W{1'b1}};
            w_r_res = cond_neg(r_rem[STAGES], r_sn[STAGES]);
        end else begin
            w_q_res = w_q_fix;
            w_r_res = w_r_fix;
        end
`else
        w_q_res = w_q_fix;
        w_r_res = w_r_fix;
`endif
    end

    // Pipeline advance: capture operands and shift every stage unless stalled.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_rem[k]   <= {W{1'b0}};
                r_qn[k]    <= {W{1'b0}};
                r_den[k]   <= {W{1'b0}};
                r_sn[k]    <= 1'b0;
                r_sd[k]    <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
                r_zero[k]  <= 1'b0;
`endif
            end
        end else if (!bus.hold) begin
            r_valid[0] <= bus.in_valid;
            r_rem[0]   <= {W{1'b0}};
            r_qn[0]    <= w_abs_n;
            r_den[0]   <= w_abs_d;
            r_sn[0]    <= w_neg_n;
            r_sd[0]    <= w_neg_d;
`ifdef DIV_ZERO_DETECT_EN
            r_zero[0]  <= (bus.denom == {W{1'b0}});
`endif
            for (int k = 1; k <= STAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_rem[k]   <= w_rem[k];
                r_qn[k]    <= w_qn[k];
                r_den[k]   <= r_den[k-1];
                r_sn[k]    <= r_sn[k-1];
                r_sd[k]    <= r_sd[k-1];
`ifdef DIV_ZERO_DETECT_EN
                r_zero[k]  <= r_zero[k-1];
`endif
            end
        end
    end

    // Output register: results load only for valid slots so bubbles keep the last values.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_quotient  <= {W{1'b0}};
            r_remain    <= {W{1'b0}};
`ifdef DIV_ZERO_DETECT_EN
            r_div_zero  <= 1'b0;
`endif
        end else if (!bus.hold) begin
            r_out_valid <= r_valid[STAGES];
`ifdef DIV_ZERO_DETECT_EN
            r_div_zero  <= r_valid[STAGES] & r_zero[STAGES];
`endif
            if (r_valid[STAGES]) begin
                r_quotient <= w_q_res;
                r_remain   <= w_r_res;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.quotient  = r_quotient;
    assign bus.remain    = r_remain;
`ifdef DIV_ZERO_DETECT_EN
    assign bus.div_zero  = r_div_zero;
`else
    assign bus.div_zero  = 1'b0;
`endif
endmodule

// File: doc/div_pipe.md
Name: div_pipe

Overview:
Parametrised, fully pipelined integer divider for the PU arithmetic path. Accepts one numer/denom pair per cycle with a valid tag and returns quotient and remainder a fixed number of cycles later, with valid, stall and signed-mode support. It is the synthesisable successor to the fixed-latency mock divider. It plugs into the divider PU behind the same quotient/remain contract, adding flow control.

Parameters:
DATA_WIDTH, 32, operand/result width in bits (>=4)
BITS_PER_STAGE, 1, quotient bits resolved per pipeline stage; must divide DATA_WIDTH (elaboration error otherwise)
SIGNED, 0, 0 = unsigned, 1 = two's-complement operands and results

Ports:
clock  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
hold  in  1  stall: freeze the entire pipeline while high
in_valid  in  1  numer/denom valid this cycle
numer  in  DATA_WIDTH  dividend
denom  in  DATA_WIDTH  divisor
out_valid  out  1  result valid
quotient  out  DATA_WIDTH  quotient
remain  out  DATA_WIDTH  remainder
div_zero  out  1  result came from denom == 0 (see Optional Feature)

Behaviour:
- Reset state: rst high clears all valid tags and data registers asynchronously. While rst is high, out_valid=0, quotient=0, remain=0, div_zero=0. First capture is on the first rising edge after rst falls.
- Structure: input register, then STAGES = DATA_WIDTH/BITS_PER_STAGE restoring-division stages, then output register.
- Latency: L = STAGES + 2 cycles from an in_valid sample to out_valid, counting only non-hold cycles. Defaults give L = 34.
- Throughput is 1 operation per non-hold cycle. Back-to-back operations are preserved in order with no bubbles inserted.
- in_valid=0 inserts a bubble that travels with the pipeline. out_valid=0 for that slot, and quotient/remain hold their last values (not cleared).
- hold=1:
  - every register, including the outputs, keeps its value;
  - in_valid/numer/denom are ignored that cycle;
  - outputs stay stable, and out_valid stays at its current value.
- Unsigned arithmetic: quotient = floor(numer/denom), remain = numer - quotient*denom.
- Signed arithmetic (SIGNED=1):
  - magnitudes are divided, then signs are restored in the output register;
  - truncation is toward zero; remain takes the sign of numer;
  - overflow case MIN/-1 gives quotient = MIN, remain = 0 (wraps, no flag).
- Division by zero (denom=0): quotient = all ones, remain = numer (unsigned and signed alike). The result keeps its pipeline slot and latency.
- Each stage carries its own partial remainder, divisor and sign bits, so in-flight operations never interact.
- Reset mid-operation: all in-flight results are discarded, and no out_valid pulse appears for them after reset.

Optional Feature:
Macro DIV_ZERO_DETECT_EN.
- Defined: a per-stage zero flag travels with each operation. div_zero equals that flag, qualified by out_valid, and updates with the output register. The divide-by-zero result values above are forced explicitly.
- Undefined:
  - div_zero is tied 0;
  - no zero-detect logic is built;
  - the denom=0 results are whatever the restoring datapath produces (unsigned: all-ones / numer; signed: unspecified);
  - the bench skips the signed denom=0 value checks.

Test Plan:
- Unsigned defaults: 100/7 at cycle 0 -> out_valid for exactly 1 cycle at cycle 34, quotient=14, remain=2.
- Streaming: 40 consecutive random pairs, with in_valid low on every 5th cycle -> results match a reference model in order, bubbles line up, zero throughput loss.
- Stall: hold high for 5 cycles at cycle 10 after issuing 100/7 -> result appears at cycle 39, and outputs never change during hold.
- Signed (SIGNED=1, DATA_WIDTH=16):
  - -7/2 -> quotient=-3, remain=-1;
  - 7/-2 -> quotient=-3, remain=1;
  - -32768/-1 -> quotient=-32768, remain=0.
- Divide by zero with DIV_ZERO_DETECT_EN: 0x1234/0 -> quotient=0xFFFFFFFF, remain=0x1234, div_zero=1. The neighbouring ops in flight show div_zero=0.
- Reset: assert rst mid-stream for 1 cycle asynchronously (between edges) -> out_valid drops immediately, and no stale results emerge in the following 34 cycles.
